// File: rtl/goertzel_sample_buffer_if.sv
// Sample-stream and loop-core port bundle for goertzel_sample_buffer.
// master = upstream source plus Goertzel core, slave = the buffer itself.
interface goertzel_sample_buffer_if #(
    parameter int B_W = 8,
    parameter int A_W = 9
);
    logic [B_W-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] read_address;
    logic [B_W-1:0] data_n;
    logic           start;
    logic           done;
    logic           busy;

    modport master (
        output in_data, in_valid, read_address, done,
        input  in_ready, data_n, start, busy
    );

    modport slave (
        input  in_data, in_valid, read_address, done,
        output in_ready, data_n, start, busy
    );
endinterface

// File: rtl/goertzel_sample_buffer.sv
// Frame capture buffer for the Goertzel loop core: fills 2^A_W samples, pulses start, serves reads until done.
// Optional feature macro GOERTZEL_BUF_DROP_EN: accept-and-discard samples while serving, counted in drop_cnt.
module goertzel_sample_buffer #(
    parameter int B_W = 8,
    parameter int A_W = 9
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     arm,
    goertzel_sample_buffer_if.slave  bus,
    output logic [7:0]               frame_cnt
`ifdef GOERTZEL_BUF_DROP_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);
    localparam int DEPTH = 1 << A_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        LAUNCH = 2'd2,
        SERVE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [A_W-1:0] wr_ptr_q, wr_ptr_d;
    logic           in_ready_q, in_ready_d;
    logic           start_q, start_d;
    logic           busy_q, busy_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic [B_W-1:0] data_n_q;
    logic           xfer_s;
    logic           wr_en_s;

    logic [B_W-1:0] mem [0:DEPTH-1];

    // Next-state and output decode; in_ready/start are registered from the next state.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        wr_en_s     = 1'b0;
        xfer_s      = bus.in_valid && in_ready_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d  = FILL;
                    wr_ptr_d = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            FILL: begin
                if (xfer_s) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + A_W'(1);
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
                // Disarming throws away the partial frame, but this cycle's sample is still written.
                if (!arm) begin
                    state_d  = IDLE;
                    wr_ptr_d = '0;
                end else if (xfer_s && (wr_ptr_q == {A_W{1'b1}})) begin
                    state_d  = LAUNCH;
                end else begin
                    state_d  = FILL;
                end
            end
            LAUNCH: begin
                state_d     = SERVE;
                busy_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            SERVE: begin
                if (bus.done) begin
                    state_d  = arm ? FILL : IDLE;
                    busy_d   = 1'b0;
                    wr_ptr_d = '0;
                end else begin
                    state_d  = SERVE;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_ptr_d = '0;
                busy_d   = 1'b0;
            end
        endcase
`ifdef GOERTZEL_BUF_DROP_EN
        in_ready_d = (state_d == FILL) || (state_d == SERVE);
`else
        in_ready_d = (state_d == FILL);
`endif
        start_d = (state_d == LAUNCH);
    end

    // Control state and registered outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Sample memory write port; contents are intentionally not reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    // Registered read port, updated in every state.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            data_n_q <= '0;
        end else begin
            data_n_q <= mem[bus.read_address];
        end
    end

`ifdef GOERTZEL_BUF_DROP_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Discarded-sample counter, saturating, restarted with each new frame.
    always_comb begin
        if (state_q == LAUNCH) begin
            drop_cnt_d = 16'd0;
        end else if ((state_q == SERVE) && xfer_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.start    = start_q;
    assign bus.busy     = busy_q;
    assign bus.data_n   = data_n_q;
    assign frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_goertzel_sample_buffer.sv
// Directed self-checking bench for goertzel_sample_buffer (default build, plus drop variant when the macro is set).
module tb_goertzel_sample_buffer;
    logic        sys_clk = 1'b0;
    logic        rst;
    logic        arm;
    logic [7:0]  frame_cnt;
`ifdef GOERTZEL_BUF_DROP_EN
    logic [15:0] drop_cnt;
`endif
    int tests = 0;
    int fails = 0;

    goertzel_sample_buffer_if bus ();

    goertzel_sample_buffer dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .arm       (arm),
        .bus       (bus),
        .frame_cnt (frame_cnt)
`ifdef GOERTZEL_BUF_DROP_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Offers samples until n transfers happen or the cycle budget runs out; reports start pulses seen.
    task automatic stream(input int n, input logic use_const, input logic [7:0] cval,
                          output int xfers, output int starts, output int first_start);
        int   cycles;
        logic took;
        cycles      = 0;
        xfers       = 0;
        starts      = 0;
        first_start = -1;
        while ((xfers < n) && (cycles < 2000)) begin
            bus.in_data  = use_const ? cval : 8'(xfers);
            bus.in_valid = 1'b1;
            took         = bus.in_ready;
            tick();
            cycles++;
            if (took) xfers++;
            if (bus.start) begin
                starts++;
                if (first_start < 0) first_start = xfers;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.read_address = 9'd0; bus.done = 1'b0;
        tick(); tick();
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        tests++; if (bus.start !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", bus.start); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.data_n !== 8'h00) begin fails++; $display("FAIL reset_data_n got %h want 00", bus.data_n); end
        tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        rst = 1'b0;
        tick(); tick();
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL idle_unarmed_in_ready got %b want 0", bus.in_ready); end
    endtask

    task automatic test_fill();
        int x, s, fs;
        arm = 1'b1;
        tick();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL fill_in_ready got %b want 1", bus.in_ready); end
        stream(512, 1'b0, 8'h00, x, s, fs);
        tests++; if (x !== 512) begin fails++; $display("FAIL fill_xfers got %0d want 512", x); end
        tests++; if (s !== 1 || fs !== 512) begin fails++; $display("FAIL fill_start_count got %0d at %0d want 1 at 512", s, fs); end
        tests++; if (bus.start !== 1'b1) begin fails++; $display("FAIL fill_start_now got %b want 1", bus.start); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL launch_busy got %b want 0", bus.busy); end
        tick();
        tests++; if (bus.start !== 1'b0) begin fails++; $display("FAIL start_width got %b want 0", bus.start); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL serve_busy got %b want 1", bus.busy); end
        tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL frame_cnt1 got %0d want 1", frame_cnt); end
    endtask

    task automatic test_read_sweep();
        for (int a = 0; a < 512; a++) begin
            bus.read_address = 9'(a);
            tick();
            tests++;
            if (bus.data_n !== 8'(a)) begin fails++; $display("FAIL sweep addr %0d got %h want %h", a, bus.data_n, 8'(a)); end
        end
        tests++; if (bus.data_n !== 8'hFF) begin fails++; $display("FAIL sweep_last got %h want ff", bus.data_n); end
    endtask

    task automatic test_serve_input();
`ifdef GOERTZEL_BUF_DROP_EN
        int offered;
        offered = 0;
        bus.in_data = 8'h77;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            if (bus.in_ready === 1'b1) offered++;
            tick();
        end
        bus.in_valid = 1'b0;
        tests++; if (offered !== 100) begin fails++; $display("FAIL drop_in_ready got %0d accepted want 100", offered); end
        tests++; if (drop_cnt !== 16'd100) begin fails++; $display("FAIL drop_cnt got %0d want 100", drop_cnt); end
`else
        int ready_seen;
        ready_seen = 0;
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.in_ready !== 1'b0) ready_seen++;
        end
        bus.in_valid = 1'b0;
        tests++; if (ready_seen !== 0) begin fails++; $display("FAIL serve_backpressure got %0d ready cycles want 0", ready_seen); end
`endif
        bus.read_address = 9'd0;
        tick();
        tests++; if (bus.data_n !== 8'h00) begin fails++; $display("FAIL serve_mem_intact got %h want 00", bus.data_n); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL serve_still_busy got %b want 1", bus.busy); end
    endtask

    task automatic test_done_refill();
        int x, s, fs;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL done_busy got %b want 0", bus.busy); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL done_in_ready got %b want 1", bus.in_ready); end
        stream(512, 1'b1, 8'hA5, x, s, fs);
        tests++; if (s !== 1 || bus.start !== 1'b1) begin fails++; $display("FAIL frame2_start got %0d pulses now %b want 1 and 1", s, bus.start); end
        tick();
        tests++; if (frame_cnt !== 8'd2) begin fails++; $display("FAIL frame_cnt2 got %0d want 2", frame_cnt); end
`ifdef GOERTZEL_BUF_DROP_EN
        tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL drop_cnt_clear got %0d want 0", drop_cnt); end
`endif
        bus.read_address = 9'd37;
        tick();
        tests++; if (bus.data_n !== 8'hA5) begin fails++; $display("FAIL frame2_read37 got %h want a5", bus.data_n); end
    endtask

    task automatic test_abort();
        int x, s, fs, bad;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        stream(200, 1'b0, 8'h00, x, s, fs);
        tests++; if (x !== 200 || s !== 0) begin fails++; $display("FAIL abort_partial got %0d xfers %0d starts want 200 0", x, s); end
        arm = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.in_ready !== 1'b0 || bus.start !== 1'b0) bad++;
            tick();
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL abort_idle got %0d bad cycles want 0", bad); end
        arm = 1'b1;
        tick();
        stream(511, 1'b0, 8'h00, x, s, fs);
        tests++; if (x !== 511 || s !== 0) begin fails++; $display("FAIL rearm_early_start got %0d xfers %0d starts want 511 0", x, s); end
        stream(1, 1'b0, 8'hFF, x, s, fs);
        tests++; if (bus.start !== 1'b1) begin fails++; $display("FAIL rearm_start got %b want 1", bus.start); end
        tick();
        tests++; if (frame_cnt !== 8'd3) begin fails++; $display("FAIL frame_cnt3 got %0d want 3", frame_cnt); end
        bus.read_address = 9'd300;
        tick();
        tests++; if (bus.data_n !== 8'h2C) begin fails++; $display("FAIL rearm_read300 got %h want 2c", bus.data_n); end
    endtask

    task automatic test_reset_launch();
        int x, s, fs, bad;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        stream(512, 1'b1, 8'h5A, x, s, fs);
        tests++; if (bus.start !== 1'b1) begin fails++; $display("FAIL pre_reset_start got %b want 1", bus.start); end
        rst = 1'b1;
        #1;
        tests++; if (bus.start !== 1'b0) begin fails++; $display("FAIL rst_launch_start got %b want 0", bus.start); end
        tests++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_launch_busy_ready got %b %b want 0 0", bus.busy, bus.in_ready); end
        tests++; if (frame_cnt !== 8'd0 || bus.data_n !== 8'h00) begin fails++; $display("FAIL rst_launch_cnt_data got %0d %h want 0 00", frame_cnt, bus.data_n); end
        arm = 1'b0;
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.start !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL rst_launch_idle got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reset_serve();
        int x, s, fs;
        arm = 1'b1;
        tick();
        stream(512, 1'b1, 8'h3C, x, s, fs);
        tick();
        tests++; if (bus.busy !== 1'b1 || frame_cnt !== 8'd1) begin fails++; $display("FAIL serve2_state got busy %b cnt %0d want 1 1", bus.busy, frame_cnt); end
        bus.read_address = 9'd9;
        tick();
        tests++; if (bus.data_n !== 8'h3C) begin fails++; $display("FAIL serve2_read got %h want 3c", bus.data_n); end
        rst = 1'b1;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.start !== 1'b0) begin fails++; $display("FAIL rst_serve_busy_start got %b %b want 0 0", bus.busy, bus.start); end
        tests++; if (bus.data_n !== 8'h00 || frame_cnt !== 8'd0) begin fails++; $display("FAIL rst_serve_data_cnt got %h %0d want 00 0", bus.data_n, frame_cnt); end
        arm = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        tests++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL rst_serve_idle got %b %b want 0 0", bus.in_ready, bus.busy); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_sweep();
        test_serve_input();
        test_done_refill();
        test_abort();
        test_reset_launch();
        test_reset_serve();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
